dpram_port_arbiter: RTL and testbench

Shares one port of the byte-enabled true dual-port RAM (registered read, 1-cycle latency) between NUM_REQ requesters. Round-robin arbitration with valid/ready handshake. Optional lock holds ownership for multi-beat sequences, with a forced release after MAX_LOCK beats. Returns read data with the owner's ID one cycle after acceptance. One instance sits in front of each RAM port that needs sharing.

---
 rtl/dpram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one port of a byte-enabled dual-port RAM between
// NUM_REQ requesters, with optional bounded lock and a tagged read response.
//
// state       | meaning
// ST_UNLOCKED | round-robin grant from r_rr_ptr among all valid requesters
// ST_LOCKED   | only r_owner may be granted; released by lock=0 or MAX_LOCK beats
module dpram_port_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int ADDRESS_WIDTH = 6,
    parameter int BYTE_WIDTH    = 8,
    parameter int BYTES         = 4,
    parameter int DATA_WIDTH_R  = BYTE_WIDTH * BYTES,
    parameter int MAX_LOCK      = 8,
    localparam int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_WIDTH    = $clog2(MAX_LOCK + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    output logic [NUM_REQ-1:0]                o_req_ready,
    input  logic [NUM_REQ-1:0]                i_req_we,
    input  logic [NUM_REQ-1:0]                i_req_lock,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_REQ*BYTES-1:0]          i_req_be,
    input  logic [NUM_REQ*BYTE_WIDTH-1:0]     i_req_wdata,
    output logic [ADDRESS_WIDTH-1:0]          o_ram_addr,
    output logic [BYTES-1:0]                  o_ram_be,
    output logic [BYTE_WIDTH-1:0]             o_ram_din,
    output logic                              o_ram_we,
    input  logic [DATA_WIDTH_R-1:0]           i_ram_dout,
    output logic                              o_rsp_valid,
    output logic [ID_WIDTH-1:0]               o_rsp_id,
    output logic [DATA_WIDTH_R-1:0]           o_rsp_rdata
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]    r_owner, w_owner_nxt;
    logic [ID_WIDTH-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_WIDTH-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    logic                   r_rsp_valid;
    logic [ID_WIDTH-1:0]    r_rsp_id;

    logic                   w_found_hi, w_found_lo, w_owner_vld;
    logic [ID_WIDTH-1:0]    w_idx_hi, w_idx_lo;
    logic                   w_grant_vld;
    logic [ID_WIDTH-1:0]    w_grant_idx;
    logic                   w_grant_we, w_grant_lock;
    logic [ID_WIDTH-1:0]    w_grant_succ;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    // Search from r_rr_ptr upward first, wrapping to the lowest valid index.
    always_comb begin
        w_found_hi  = 1'b0;
        w_found_lo  = 1'b0;
        w_idx_hi    = '0;
        w_idx_lo    = '0;
        w_owner_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i]) begin
                if (!w_found_lo) begin
                    w_found_lo = 1'b1;
                    w_idx_lo   = ID_WIDTH'(i);
                end
                if (!w_found_hi && (ID_WIDTH'(i) >= r_rr_ptr)) begin
                    w_found_hi = 1'b1;
                    w_idx_hi   = ID_WIDTH'(i);
                end
            end
            if (ID_WIDTH'(i) == r_owner) begin
                w_owner_vld = i_req_valid[i];
            end
        end
        if (r_state == ST_LOCKED) begin
            w_grant_vld = w_owner_vld;
            w_grant_idx = r_owner;
        end else begin
            w_grant_vld = w_found_lo;
            w_grant_idx = w_found_hi ? w_idx_hi : w_idx_lo;
        end
    end

    always_comb begin
        o_req_ready  = '0;
        o_ram_addr   = '0;
        o_ram_be     = '0;
        o_ram_din    = '0;
        o_ram_we     = 1'b0;
        w_grant_we   = 1'b0;
        w_grant_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_vld && (w_grant_idx == ID_WIDTH'(i))) begin
                o_req_ready[i] = 1'b1;
                o_ram_addr     = i_req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                o_ram_be       = i_req_be[i*BYTES +: BYTES];
                o_ram_din      = i_req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                o_ram_we       = i_req_we[i];
                w_grant_we     = i_req_we[i];
                w_grant_lock   = i_req_lock[i];
            end
        end
    end

    assign w_grant_succ = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                  : w_grant_idx + ID_WIDTH'(1);
    assign w_cnt_inc    = r_lock_cnt + CNT_WIDTH'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_grant_vld) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_grant_lock) begin
                        w_state_nxt    = ST_LOCKED;
                        w_owner_nxt    = w_grant_idx;
                        w_lock_cnt_nxt = CNT_WIDTH'(1);
                    end else begin
                        w_rr_ptr_nxt   = w_grant_succ;
                    end
                end
                ST_LOCKED: begin
                    w_lock_cnt_nxt = w_cnt_inc;
                    // Forced release ignores req_lock so no owner can starve the rest.
                    if (!w_grant_lock || (w_cnt_inc == CNT_WIDTH'(MAX_LOCK))) begin
                        w_state_nxt    = ST_UNLOCKED;
                        w_lock_cnt_nxt = '0;
                        w_rr_ptr_nxt   = w_grant_succ;
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNLOCKED;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // RAM read data arrives one cycle after acceptance; tag it to line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_grant_vld && !w_grant_we;
            r_rsp_id    <= w_grant_vld ? w_grant_idx : '0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_rdata = i_ram_dout;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter: behavioural RAM, response scoreboard,
// immediate-assertion checks on grants, RAM port fields and tagged responses.
module tb_dpram_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 6;
    localparam int BW = 8;
    localparam int NB = 4;
    localparam int DW = BW * NB;
    localparam int ML = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     i_req_valid, o_req_ready, i_req_we, i_req_lock;
    logic [NR*AW-1:0]  i_req_addr;
    logic [NR*NB-1:0]  i_req_be;
    logic [NR*BW-1:0]  i_req_wdata;
    logic [AW-1:0]     o_ram_addr;
    logic [NB-1:0]     o_ram_be;
    logic [BW-1:0]     o_ram_din;
    logic              o_ram_we;
    logic [DW-1:0]     i_ram_dout;
    logic              o_rsp_valid;
    logic [1:0]        o_rsp_id;
    logic [DW-1:0]     o_rsp_rdata;

    dpram_port_arbiter #(
        .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .BYTE_WIDTH(BW), .BYTES(NB),
        .DATA_WIDTH_R(DW), .MAX_LOCK(ML)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_lock(i_req_lock),
        .i_req_addr(i_req_addr), .i_req_be(i_req_be), .i_req_wdata(i_req_wdata),
        .o_ram_addr(o_ram_addr), .o_ram_be(o_ram_be), .o_ram_din(o_ram_din),
        .o_ram_we(o_ram_we), .i_ram_dout(i_ram_dout),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_rdata(o_rsp_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM port: byte-lane write with replicated byte, registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (o_ram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (o_ram_be[b]) mem[o_ram_addr][b*BW +: BW] <= o_ram_din;
            end
        end
        i_ram_dout <= mem[o_ram_addr];
    end

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ":rsp_valid"}, 32'(o_rsp_valid), 32'd1);
            chk({tag, ":rsp_id"}, 32'(o_rsp_id), 32'(e.id));
            chk({tag, ":rsp_rdata"}, o_rsp_rdata, e.data);
        end else begin
            chk({tag, ":rsp_idle"}, 32'(o_rsp_valid), 32'd0);
        end
    endtask

    // One beat: check the response of the previous beat, drive this beat,
    // check the combinational grant and RAM fields, queue the expected response.
    task automatic step(input logic [2:0] v, input logic [2:0] we, input logic [2:0] lk,
                        input logic [2:0] exp_rdy, input logic [5:0] a, input logic [3:0] be,
                        input logic [7:0] wd, input logic [31:0] exp_data, input string tag);
        int   g;
        exp_t e;
        @(posedge clk); #1;
        check_rsp(tag);
        i_req_valid = v;
        i_req_we    = we;
        i_req_lock  = lk;
        i_req_addr  = {3{a}};
        i_req_be    = {3{be}};
        i_req_wdata = {wd + 8'd2, wd + 8'd1, wd};
        #1;
        chk({tag, ":ready"}, 32'(o_req_ready), 32'(exp_rdy));
        g = -1;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) g = i;
        if (g < 0) begin
            chk({tag, ":ram_we"}, 32'(o_ram_we), 32'd0);
            chk({tag, ":ram_be"}, 32'(o_ram_be), 32'd0);
            chk({tag, ":ram_addr"}, 32'(o_ram_addr), 32'd0);
        end else begin
            chk({tag, ":ram_we"}, 32'(o_ram_we), 32'(we[g]));
            chk({tag, ":ram_be"}, 32'(o_ram_be), 32'(be));
            chk({tag, ":ram_addr"}, 32'(o_ram_addr), 32'(a));
            chk({tag, ":ram_din"}, 32'(o_ram_din), 32'(wd + 8'(g)));
            if (!we[g]) begin
                e.id   = 2'(g);
                e.data = exp_data;
                q.push_back(e);
            end
        end
    endtask

    localparam logic [31:0] RD5 = 32'h0000_A5A5;

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
        rst_n       = 1'b0;
        i_req_valid = '0;
        i_req_we    = '0;
        i_req_lock  = '0;
        i_req_addr  = '0;
        i_req_be    = '0;
        i_req_wdata = '0;

        @(posedge clk); #1;
        chk("rst:ready", 32'(o_req_ready), 32'd0);
        chk("rst:rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst:rsp_id", 32'(o_rsp_id), 32'd0);
        chk("rst:ram_we", 32'(o_ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) step(3'b000, 3'b000, 3'b000, 3'b000, 6'd0, 4'h0, 8'h00, 0, "idle");

        step(3'b001, 3'b001, 3'b000, 3'b001, 6'd5, 4'b0011, 8'hA5, 0, "wr0");
        step(3'b001, 3'b000, 3'b000, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "rd0");
        step(3'b100, 3'b000, 3'b000, 3'b100, 6'd5, 4'hF, 8'h00, RD5, "rd2");

        step(3'b111, 3'b000, 3'b000, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "rr_a0");
        step(3'b111, 3'b000, 3'b000, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "rr_a1");
        step(3'b111, 3'b000, 3'b000, 3'b100, 6'd5, 4'hF, 8'h00, RD5, "rr_a2");
        step(3'b111, 3'b000, 3'b000, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "rr_b0");
        step(3'b111, 3'b000, 3'b000, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "rr_b1");
        step(3'b111, 3'b000, 3'b000, 3'b100, 6'd5, 4'hF, 8'h00, RD5, "rr_b2");

        step(3'b001, 3'b000, 3'b000, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "pre_lock");
        step(3'b111, 3'b000, 3'b010, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "lock1_1");
        step(3'b111, 3'b000, 3'b010, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "lock1_2");
        step(3'b111, 3'b000, 3'b010, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "lock1_3");
        step(3'b111, 3'b000, 3'b000, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "lock1_rel");
        step(3'b111, 3'b000, 3'b000, 3'b100, 6'd5, 4'hF, 8'h00, RD5, "after_rel2");
        step(3'b111, 3'b000, 3'b000, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "after_rel0");

        step(3'b010, 3'b000, 3'b000, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "pre_force");
        for (int k = 0; k < ML; k++)
            step(3'b111, 3'b000, 3'b100, 3'b100, 6'd5, 4'hF, 8'h00, RD5, "force_lock2");
        step(3'b111, 3'b000, 3'b100, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "force_next0");

        step(3'b010, 3'b000, 3'b010, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "rlock1_a");
        step(3'b011, 3'b000, 3'b010, 3'b010, 6'd5, 4'hF, 8'h00, RD5, "rlock1_b");
        @(posedge clk); #1;
        check_rsp("rlock1_pending");
        i_req_valid = '0;
        i_req_lock  = '0;
        rst_n       = 1'b0;
        #1;
        chk("midrst:rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("midrst:ready", 32'(o_req_ready), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b011, 3'b000, 3'b000, 3'b001, 6'd5, 4'hF, 8'h00, RD5, "post_rst");
        step(3'b000, 3'b000, 3'b000, 3'b000, 6'd0, 4'h0, 8'h00, 0, "flush");
        step(3'b000, 3'b000, 3'b000, 3'b000, 6'd0, 4'h0, 8'h00, 0, "flush_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
